// File: rtl/dp_arbiter_sched.sv
// Round-robin scheduler that shares one enable-driven operand datapath between
// two requesters and returns id-tagged results, stopping after N_OPS operations.
module dp_arbiter_sched #(
  parameter int N_OPS = 8,
  parameter int LAT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       sumen,
  output logic       multien,
  output logic       consten,
  output logic       erroren,
  input  logic [7:0] dp_result,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [3:0] count,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  // Handshake: a pair transfers on any cycle where reqN_valid && reqN_ready.
  // ready is raised combinationally in ARB for the granted requester only, and
  // only while its valid is high; responses carry no backpressure.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(LAT - 1);
  localparam logic [3:0] OPS_LAST  = 4'(N_OPS);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       prio_q, prio_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       id_q, id_d;
  logic [1:0] wait_q, wait_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  logic grant_any;
  logic grant_id;
  logic is_err;

  // With both valid the pointer decides; otherwise the lone valid wins.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign is_err    = (op_a_q == 4'd0) || (op_b_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prio_d     = prio_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sumen      = 1'b0;
    multien    = 1'b0;
    consten    = 1'b0;
    erroren    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = 4'd0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          op_a_d     = grant_id ? req1_a : req0_a;
          op_b_d     = grant_id ? req1_b : req0_b;
          id_d       = grant_id;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d = 2'd0;
        if (is_err) begin
          erroren    = 1'b1;
          rsp_data_d = 8'd0;
          state_d    = S_RESP;
        end else begin
          if (op_a_q < op_b_q)       multien = 1'b1;
          else if (op_a_q == op_b_q) consten = 1'b1;
          else                       sumen   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          rsp_data_d = dp_result;
          state_d    = S_RESP;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_RESP: begin
        count_d = count_q + 4'd1;
        prio_d  = ~prio_q;
        state_d = (count_d == OPS_LAST) ? S_IDLE : S_ARB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= 4'd0;
      prio_q     <= 1'b0;
      op_a_q     <= 4'd0;
      op_b_q     <= 4'd0;
      id_q       <= 1'b0;
      wait_q     <= 2'd0;
      rsp_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      wait_q     <= wait_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && is_err;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dp_arbiter_sched.sv
// Directed bench: instance a (N_OPS=4, LAT=1) covers handshake, classification,
// arbitration, batch end and mid-operation reset; instance b (LAT=3) covers wait latency.
module tb_dp_arbiter_sched;

  logic       clk;
  logic       reset;
  logic       start;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] dp_result;

  logic       a_req0_ready, a_req1_ready, a_sumen, a_multien, a_consten, a_erroren;
  logic [3:0] a_op_a, a_op_b, a_count;
  logic       a_rsp_valid, a_rsp_id, a_rsp_err, a_busy, a_done;
  logic [7:0] a_rsp_data;
  logic [2:0] a_dbg_state;

  logic       b_req0_ready, b_req1_ready, b_sumen, b_multien, b_consten, b_erroren;
  logic [3:0] b_op_a, b_op_b, b_count;
  logic       b_rsp_valid, b_rsp_id, b_rsp_err, b_busy, b_done;
  logic [7:0] b_rsp_data;
  logic [2:0] b_dbg_state;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  dp_arbiter_sched #(.N_OPS(4), .LAT(1)) u_a (
    .clk(clk), .reset(reset), .start(start),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(a_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(a_req1_ready),
    .op_a(a_op_a), .op_b(a_op_b),
    .sumen(a_sumen), .multien(a_multien), .consten(a_consten), .erroren(a_erroren),
    .dp_result(dp_result),
    .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
    .count(a_count), .busy(a_busy), .done(a_done), .dbg_state(a_dbg_state)
  );

  dp_arbiter_sched #(.N_OPS(8), .LAT(3)) u_b (
    .clk(clk), .reset(reset), .start(start),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(b_req1_ready),
    .op_a(b_op_a), .op_b(b_op_b),
    .sumen(b_sumen), .multien(b_multien), .consten(b_consten), .erroren(b_erroren),
    .dp_result(dp_result),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .count(b_count), .busy(b_busy), .done(b_done), .dbg_state(b_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] a_en();
    return {4'd0, a_sumen, a_multien, a_consten, a_erroren};
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
    dp_result = 8'd0;
    tick(); tick();
    #1;
    check("rst_done", a_done, 1); check("rst_busy", a_busy, 0);
    check("rst_count", a_count, 0); check("rst_op_a", a_op_a, 0);
    check("rst_op_b", a_op_b, 0); check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_id", a_rsp_id, 0); check("rst_rsp_data", a_rsp_data, 0);
    check("rst_rsp_err", a_rsp_err, 0); check("rst_ready0", a_req0_ready, 0);
    check("rst_enables", a_en(), 0);

    // req0 alone, 3 < 5 -> multiply
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    #1;
    check("t1_ready0", a_req0_ready, 1); check("t1_ready1", a_req1_ready, 0);
    check("t1_busy", a_busy, 1);
    tick();
    req0_valid = 1'b0; dp_result = 8'd15;
    #1;
    check("t1_issue_en", a_en(), 8'b0100);
    check("t1_op_a", a_op_a, 3); check("t1_op_b", a_op_b, 5);
    tick(); #1;
    check("t1_wait_en", a_en(), 0); check("t1_wait_rsp", a_rsp_valid, 0);
    tick(); #1;
    check("t1_rsp_valid", a_rsp_valid, 1); check("t1_rsp_id", a_rsp_id, 0);
    check("t1_rsp_data", a_rsp_data, 15); check("t1_rsp_err", a_rsp_err, 0);
    tick(); #1;
    check("t1_after_rsp", a_rsp_valid, 0); check("t1_count", a_count, 1);

    // req1 alone with A=0 -> error path, no WAIT
    req1_valid = 1'b1; req1_a = 4'd0; req1_b = 4'd7;
    #1;
    check("t2_ready1", a_req1_ready, 1); check("t2_ready0", a_req0_ready, 0);
    tick();
    req1_valid = 1'b0;
    #1;
    check("t2_issue_en", a_en(), 8'b0001);
    tick(); #1;
    check("t2_rsp_valid", a_rsp_valid, 1); check("t2_rsp_err", a_rsp_err, 1);
    check("t2_rsp_data", a_rsp_data, 0); check("t2_rsp_id", a_rsp_id, 1);
    tick(); #1;
    check("t2_count", a_count, 2); check("t2_en_off", a_en(), 0);

    // both requesters continuously valid: (9,4) sum, (6,6) const, batch of 4
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; dp_result = 8'hA5;
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd4;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd6;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(i % 2));
      check("t3_ready0", a_req0_ready, (i % 2 == 0) ? 8'd1 : 8'd0);
      check("t3_ready1", a_req1_ready, (i % 2 == 1) ? 8'd1 : 8'd0);
      tick(); #1;
      check("t3_issue_en", a_en(), (i % 2 == 0) ? 8'b1000 : 8'b0010);
      tick(); #1;
      check("t3_wait_rsp", a_rsp_valid, 0);
      tick(); #1;
      check("t3_rsp_valid", a_rsp_valid, 1);
      check("t3_rsp_id", a_rsp_id, exp_q.pop_front());
      check("t3_rsp_data", a_rsp_data, 8'hA5);
      check("t3_count_in_rsp", a_count, 8'(i));
      tick(); #1;
    end
    check("t4_count", a_count, 4); check("t4_done", a_done, 1);
    for (int k = 0; k < 3; k++) begin
      check("t4_idle_ready0", a_req0_ready, 0);
      check("t4_idle_ready1", a_req1_ready, 0);
      tick(); #1;
      check("t4_idle_count", a_count, 4); check("t4_idle_busy", a_busy, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("t4_restart_count", a_count, 0); check("t4_restart_ready0", a_req0_ready, 1);

    // one op for req0 moves pointer to req1, then reset during req1's WAIT
    tick(); #1;
    check("t5_issue_en", a_en(), 8'b1000);
    tick(); tick(); tick(); #1;
    check("t5_ready1", a_req1_ready, 1); check("t5_ready0", a_req0_ready, 0);
    tick(); #1;
    check("t5_issue_en1", a_en(), 8'b0010);
    tick();
    reset = 1'b1;
    #1;
    check("t5_in_wait", a_busy, 1);
    tick();
    reset = 1'b0;
    #1;
    check("t5_no_rsp", a_rsp_valid, 0); check("t5_count", a_count, 0);
    check("t5_done", a_done, 1);
    tick(); #1;
    check("t5_no_rsp2", a_rsp_valid, 0); check("t5_done2", a_done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("t5_first_ready0", a_req0_ready, 1); check("t5_first_ready1", a_req1_ready, 0);

    // LAT=3 instance: (2,2) const, dp_result sampled on the last WAIT cycle
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req1_valid = 1'b0;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("t6_ready0", b_req0_ready, 1);
    tick();
    req0_valid = 1'b0; dp_result = 8'h11;
    #1;
    check("t6_issue_en", {4'd0, b_sumen, b_multien, b_consten, b_erroren}, 8'b0010);
    tick(); dp_result = 8'h22; #1;
    check("t6_wait1", b_rsp_valid, 0);
    tick(); dp_result = 8'h33; #1;
    check("t6_wait2", b_rsp_valid, 0);
    tick(); dp_result = 8'h44; #1;
    check("t6_wait3", b_rsp_valid, 0);
    tick(); dp_result = 8'h55; #1;
    check("t6_rsp_valid", b_rsp_valid, 1); check("t6_rsp_data", b_rsp_data, 8'h44);
    check("t6_rsp_id", b_rsp_id, 0); check("t6_rsp_err", b_rsp_err, 0);
    tick(); #1;
    check("t6_after_rsp", b_rsp_valid, 0); check("t6_count", b_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dp_arbiter_sched.md
Name: dp_arbiter_sched

Overview:
- Shares one operand datapath (sum / multiply / const / error units, enable-driven) between two requesters.
- Each requester submits 4-bit A,B pairs with a valid/ready handshake. The block arbitrates round-robin, classifies the pair, pulses exactly one unit enable and waits the datapath latency.
- It returns the result tagged with the requester id and stops after N_OPS completed operations.
- Sits between the requester front-ends and the arithmetic datapath; replaces single-requester sequencing.

Parameters:
- N_OPS, 8, operations per batch; legal range 1..15.
- LAT, 1, cycles from the enable pulse to a valid dp_result; legal range 1..3.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begins a batch; sampled only in IDLE
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  4  requester 0 operand A
- req0_b  in  4  requester 0 operand B
- req0_ready  out  1  requester 0 pair accepted this cycle
- req1_valid / req1_a / req1_b / req1_ready  same as requester 0, for requester 1
- op_a  out  4  latched A driven to the datapath
- op_b  out  4  latched B driven to the datapath
- sumen  out  1  sum unit enable
- multien  out  1  multiply unit enable
- consten  out  1  const unit enable
- erroren  out  1  error unit enable
- dp_result  in  8  datapath result
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  requester id of the response
- rsp_data  out  8  result (0 on error)
- rsp_err  out  1  response is an error
- count  out  4  operations completed in the current batch
- busy  out  1  high in every state except IDLE
- done  out  1  high in IDLE, low otherwise

Behaviour:
- Reset:
  - state=IDLE, count=0, priority pointer selects requester 0 first.
  - op_a=op_b=0, rsp_data=0, rsp_id=0.
  - All enables, readys, rsp_valid, rsp_err and busy are 0; done=1.
- Reset asserted mid-operation:
  - Aborts the operation in flight; no response is issued.
  - Requester state is not preserved.
- States: IDLE, ARB, ISSUE, WAIT, RESP.
- IDLE:
  - readys are low.
  - start=1 -> clear count and go to ARB.
- ARB:
  - If no valid is high, stay in ARB.
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester named by the priority pointer.
  - The granted reqN_ready is combinationally high this cycle; the other ready is low.
  - On the handshake, latch a, b and id, then go to ISSUE.
- ISSUE (one cycle), classify from the latched values:
  - A==0 or B==0: erroren.
  - Else A<B: multien.
  - Else A==B: consten.
  - Else: sumen.
  - Exactly one enable is high, for this cycle only.
  - op_a/op_b hold the latched values from ISSUE through RESP.
  - Error -> RESP next cycle; otherwise -> WAIT.
- WAIT:
  - Lasts exactly LAT cycles.
  - dp_result is registered into rsp_data on the last WAIT cycle, then -> RESP.
- RESP (one cycle):
  - rsp_valid=1, rsp_id=latched id, rsp_err=1 with rsp_data=0 on error.
  - count increments.
  - Priority pointer moves to the other requester.
  - If the new count==N_OPS -> IDLE, otherwise -> ARB.
- Latency from handshake cycle T:
  - Non-error: enable at T+1, rsp_valid at T+2+LAT.
  - Error: erroren at T+1, rsp_valid at T+2.
- Responses have no backpressure; rsp_valid is strobed once per accepted pair.
- start outside IDLE is ignored.
- valid dropping in ARB before a grant is legal; that requester is simply not granted.
- At most one operation is in flight at any time.

Test Plan:
1. Reset, start, req0 only with A=3,B=5, LAT=1:
   - req0_ready in the ARB cycle.
   - multien one cycle later.
   - rsp_valid 3 cycles after the handshake with rsp_id=0 and rsp_data=dp_result.
2. Error classification, req1 with A=0,B=7:
   - erroren for one cycle.
   - rsp_valid 2 cycles after the handshake, rsp_err=1, rsp_data=0, rsp_id=1.
3. Arbitration, both requesters holding valid with pairs (9,4) and (6,6):
   - Grant order 0,1,0,1.
   - Enables alternate sumen / consten.
   - rsp_id alternates 0,1.
4. Batch end, N_OPS=4 with continuous requests:
   - After the 4th rsp_valid, count=4 and done=1.
   - readys stay low and further valids are not accepted until the next start.
5. Reset mid-operation: assert reset during WAIT:
   - No rsp_valid is issued.
   - count=0, done=1.
   - After the next start, requester 0 is granted first.
6. LAT=3, req0 with A=2,B=2:
   - consten at T+1.
   - dp_result is sampled 3 cycles after the enable.
   - rsp_valid at T+5.
